// File: rtl/i281_pkg.sv
// Shared constants and types for the i281 run controller.
package i281_pkg;

  localparam int unsigned ST_IF = 0;

  localparam logic [1:0] CAUSE_RESET   = 2'd0;
  localparam logic [1:0] CAUSE_RUN_LOW = 2'd1;
  localparam logic [1:0] CAUSE_STEP    = 2'd2;
  localparam logic [1:0] CAUSE_BP      = 2'd3;

  typedef enum logic [1:0] {
    CTL_HALTED   = 2'd0,
    CTL_RUNNING  = 2'd1,
    CTL_STEPPING = 2'd2
  } ctl_state_e;

endpackage

// File: rtl/i281_edge_detect.sv
// Rising-edge detector: registers the previous level and flags a 0->1 change.
module i281_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise_c
);

  logic r_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_prev <= 1'b0;
    else        r_prev <= i_sig;
  end

  assign o_rise_c = i_sig & ~r_prev;

endmodule

// File: rtl/i281_run_controller.sv
// Run/step/breakpoint sequencer gating the i281 core clock-enable at
// instruction boundaries, with halt status and debug counters.
module i281_run_controller
  import i281_pkg::*;
#(
  parameter int unsigned PC_W    = 6,
  parameter int unsigned STATE_W = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic                 bp_enable,
  input  logic [PC_W-1:0]      bp_addr,
  input  logic [STATE_W-1:0]   core_state,
  input  logic [PC_W-1:0]      core_pc,
  output logic                 core_enable,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W/2-1:0]   instr_count
);

  localparam int unsigned IC_W = CNT_W / 2;

  ctl_state_e        r_state;
  ctl_state_e        w_state_nxt;
  logic              r_halted;
  logic [1:0]        r_cause;
  logic [1:0]        w_cause_nxt;
  logic              r_bp_skip;
  logic              w_bp_skip_nxt;
  logic              r_step_fetched;
  logic              w_step_fetched_nxt;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [IC_W-1:0]   r_instr_count;

  logic w_boundary;
  logic w_bp_hit;
  logic w_stop;
  logic w_enable;
  logic w_fetch;
  logic w_step_rise;

  i281_edge_detect u_step_edge (
    .clock    (clock),
    .reset    (reset),
    .i_sig    (step),
    .o_rise_c (w_step_rise)
  );

  assign w_boundary = (core_state == STATE_W'(ST_IF));
  assign w_bp_hit   = bp_enable & (core_pc == bp_addr) & ~r_bp_skip;
  assign w_fetch    = w_enable & w_boundary;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= CTL_HALTED;
      r_halted       <= 1'b1;
      r_cause        <= CAUSE_RESET;
      r_bp_skip      <= 1'b0;
      r_step_fetched <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_halted       <= (w_state_nxt == CTL_HALTED);
      r_cause        <= w_cause_nxt;
      r_bp_skip      <= w_bp_skip_nxt;
      r_step_fetched <= w_step_fetched_nxt;
    end
  end

  // Stop decisions are combinational so the enable drops in the boundary cycle itself.
  always_comb begin
    w_state_nxt        = r_state;
    w_cause_nxt        = r_cause;
    w_bp_skip_nxt      = r_bp_skip;
    w_step_fetched_nxt = r_step_fetched;
    w_stop             = 1'b0;
    w_enable           = 1'b0;
    case (r_state)
      CTL_HALTED: begin
        if (run) begin
          w_state_nxt   = CTL_RUNNING;
          w_bp_skip_nxt = (r_cause == CAUSE_BP);
        end else if (w_step_rise) begin
          w_state_nxt        = CTL_STEPPING;
          w_step_fetched_nxt = 1'b0;
          w_bp_skip_nxt      = (r_cause == CAUSE_BP);
        end
      end
      CTL_RUNNING: begin
        w_stop   = w_boundary & (~run | w_bp_hit);
        w_enable = ~w_stop;
        if (w_stop) begin
          w_state_nxt = CTL_HALTED;
          w_cause_nxt = run ? CAUSE_BP : CAUSE_RUN_LOW;
        end
      end
      CTL_STEPPING: begin
        w_stop   = w_boundary & r_step_fetched;
        w_enable = ~w_stop;
        if (w_stop) begin
          w_state_nxt = CTL_HALTED;
          w_cause_nxt = CAUSE_STEP;
        end
      end
      default: w_state_nxt = CTL_HALTED;
    endcase
    if (w_enable && w_boundary) begin
      w_bp_skip_nxt = 1'b0;
      if (r_state == CTL_STEPPING) w_step_fetched_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      r_cycle_count <= r_cycle_count + CNT_W'(w_enable);
      r_instr_count <= r_instr_count + IC_W'(w_fetch);
    end
  end

  assign core_enable = w_enable;
  assign halted      = r_halted;
  assign halt_cause  = r_cause;
  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_i281_run_controller.sv
// Bench for i281_run_controller: directed vector table over a 3-instruction core
// loop plus a per-cycle scoreboard of counters and halt status.
module tb_i281_run_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        run, step, bp_enable;
  logic [5:0]  bp_addr;
  logic [4:0]  core_state;
  logic [5:0]  core_pc;
  logic        core_enable, halted;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  i281_run_controller #(.PC_W(6), .STATE_W(5), .CNT_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .bp_enable   (bp_enable),
    .bp_addr     (bp_addr),
    .core_state  (core_state),
    .core_pc     (core_pc),
    .core_enable (core_enable),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  // Core stand-in: 3 states per instruction, PC loops 4,5,6.
  initial begin
    core_state = 5'd0;
    core_pc    = 6'd4;
  end
  always @(posedge clock) begin
    if (core_enable) begin
      core_state <= (core_state == 5'd2) ? 5'd0 : core_state + 5'd1;
      if (core_state == 5'd2) core_pc <= (core_pc == 6'd6) ? 6'd4 : core_pc + 6'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the controller; pushes predicted registered outputs each edge.
  typedef struct {
    logic [31:0] cyc;
    logic [15:0] ins;
    logic        h;
    logic [1:0]  c;
  } exp_t;
  exp_t sb[$];

  localparam logic [1:0] M_H = 2'd0, M_R = 2'd1, M_S = 2'd2;
  logic [1:0]  m_state, n_state;
  logic        m_skip, n_skip, m_sf, n_sf, m_prev, m_h, n_h;
  logic [1:0]  m_c, n_c;
  logic [31:0] m_cyc, n_cyc;
  logic [15:0] m_ins, n_ins;
  logic        t_en, t_fetch;

  function automatic logic m_enable();
    logic bnd;
    bnd = (core_state == 5'd0);
    if (m_state == M_R)
      return !(bnd && (!run || (bp_enable && core_pc == bp_addr && !m_skip)));
    if (m_state == M_S)
      return !(bnd && m_sf);
    return 1'b0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state <= M_H; m_skip <= 1'b0; m_sf <= 1'b0; m_prev <= 1'b0;
      m_h <= 1'b1; m_c <= 2'd0; m_cyc <= '0; m_ins <= '0;
      sb.delete();
    end else begin
      t_en    = m_enable();
      t_fetch = t_en && (core_state == 5'd0);
      n_state = m_state; n_skip = m_skip; n_sf = m_sf; n_h = m_h; n_c = m_c;
      n_cyc   = m_cyc + (t_en ? 32'd1 : 32'd0);
      n_ins   = m_ins + (t_fetch ? 16'd1 : 16'd0);
      if (m_state == M_H) begin
        if (run) begin
          n_state = M_R; n_skip = (m_c == 2'd3); n_h = 1'b0;
        end else if (step && !m_prev) begin
          n_state = M_S; n_skip = (m_c == 2'd3); n_sf = 1'b0; n_h = 1'b0;
        end
      end else if (!t_en) begin
        n_state = M_H; n_h = 1'b1;
        n_c = (m_state == M_S) ? 2'd2 : (!run ? 2'd1 : 2'd3);
      end else if (t_fetch) begin
        n_skip = 1'b0;
        if (m_state == M_S) n_sf = 1'b1;
      end
      m_state <= n_state; m_skip <= n_skip; m_sf <= n_sf; m_prev <= step;
      m_h <= n_h; m_c <= n_c; m_cyc <= n_cyc; m_ins <= n_ins;
      sb.push_back('{n_cyc, n_ins, n_h, n_c});
    end
  end

  always @(negedge clock) begin
    exp_t e;
    #2;
    if (reset && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_cycle_count", cycle_count, e.cyc);
      chk("sb_instr_count", 32'(instr_count), 32'(e.ins));
      chk("sb_halted", 32'(halted), 32'(e.h));
      chk("sb_halt_cause", 32'(halt_cause), 32'(e.c));
    end
  end

  typedef struct {
    logic       run, step, bp_en;
    logic [5:0] bp_addr;
    int         ticks;
    logic       en, h;
    logic [1:0] c;
    logic [15:0] ins;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic b, logic [5:0] a, int t,
                              logic en, logic h, logic [1:0] c, logic [15:0] ins);
    vec_t v;
    v.run = r; v.step = s; v.bp_en = b; v.bp_addr = a; v.ticks = t;
    v.en = en; v.h = h; v.c = c; v.ins = ins;
    return v;
  endfunction

  vec_t vecs[22];

  initial begin
    // run step bp addr ticks | en halted cause instr
    vecs[0]  = mk(0, 0, 0, 6'd0, 1,  0, 1, 2'd0, 16'd0);
    vecs[1]  = mk(1, 0, 0, 6'd0, 1,  0, 1, 2'd0, 16'd0);
    vecs[2]  = mk(1, 0, 0, 6'd0, 9,  1, 0, 2'd0, 16'd0);
    vecs[3]  = mk(1, 0, 0, 6'd0, 2,  1, 0, 2'd0, 16'd3);
    vecs[4]  = mk(0, 0, 0, 6'd0, 1,  1, 0, 2'd0, 16'd4);
    vecs[5]  = mk(0, 0, 0, 6'd0, 1,  0, 0, 2'd0, 16'd4);
    vecs[6]  = mk(0, 0, 1, 6'd5, 1,  0, 1, 2'd1, 16'd4);
    vecs[7]  = mk(1, 0, 1, 6'd5, 1,  0, 1, 2'd1, 16'd4);
    vecs[8]  = mk(1, 0, 1, 6'd5, 1,  0, 0, 2'd1, 16'd4);
    vecs[9]  = mk(0, 0, 1, 6'd5, 1,  0, 1, 2'd3, 16'd4);
    vecs[10] = mk(1, 0, 1, 6'd5, 1,  0, 1, 2'd3, 16'd4);
    vecs[11] = mk(1, 0, 1, 6'd5, 9,  1, 0, 2'd3, 16'd4);
    vecs[12] = mk(1, 0, 1, 6'd5, 1,  0, 0, 2'd3, 16'd7);
    vecs[13] = mk(0, 0, 1, 6'd5, 1,  0, 1, 2'd3, 16'd7);
    vecs[14] = mk(0, 1, 1, 6'd5, 1,  0, 1, 2'd3, 16'd7);
    vecs[15] = mk(0, 1, 1, 6'd5, 3,  1, 0, 2'd3, 16'd7);
    vecs[16] = mk(0, 1, 1, 6'd5, 1,  0, 0, 2'd3, 16'd8);
    vecs[17] = mk(0, 1, 1, 6'd5, 2,  0, 1, 2'd2, 16'd8);
    vecs[18] = mk(0, 0, 0, 6'd0, 1,  0, 1, 2'd2, 16'd8);
    vecs[19] = mk(1, 1, 0, 6'd0, 1,  0, 1, 2'd2, 16'd8);
    vecs[20] = mk(1, 1, 0, 6'd0, 12, 1, 0, 2'd2, 16'd8);
    vecs[21] = mk(1, 0, 0, 6'd0, 1,  1, 0, 2'd2, 16'd12);

    reset = 1'b0; run = 1'b0; step = 1'b0; bp_enable = 1'b0; bp_addr = 6'd0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      run = vecs[i].run; step = vecs[i].step;
      bp_enable = vecs[i].bp_en; bp_addr = vecs[i].bp_addr;
      #1;
      chk($sformatf("v%0d_core_enable", i), 32'(core_enable), 32'(vecs[i].en));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].h));
      chk($sformatf("v%0d_halt_cause", i), 32'(halt_cause), 32'(vecs[i].c));
      chk($sformatf("v%0d_instr_count", i), 32'(instr_count), 32'(vecs[i].ins));
      repeat (vecs[i].ticks) @(negedge clock);
    end

    // Async reset while running: outputs clear with no clock edge.
    #3;
    chk("pre_reset_enable", 32'(core_enable), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_core_enable", 32'(core_enable), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_halt_cause", 32'(halt_cause), 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_instr_count", 32'(instr_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
